// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and the instruction field
// bit positions that both the fetch and decode stages slice on.
package cpu_pkg;

  localparam int INSTR_W  = 32;

  localparam int OP_HI    = 27;
  localparam int OP_LO    = 26;
  localparam int FUNCT_HI = 25;
  localparam int FUNCT_LO = 22;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry holding register for a fetched word and its PC; used to park a
// response that arrives while decode is stalled. Clear wins over load.
module fetch_skid_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_data,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_data,
  output logic [ADDR_W-1:0]  o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_data;
  logic [ADDR_W-1:0]  r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit_pipe.sv
// Instruction fetch stage: one outstanding imem request, IF/ID slot with a
// skid entry for stalls, and redirect squashing of wrong-path responses.
module fetch_unit_pipe
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_next,
  output logic [1:0]         if_op,
  output logic [3:0]         if_funct,
  output logic [3:0]         if_rd,
  output fetch_state_t       dbg_state
);

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic               w_load;
  logic               w_from_skid;
  logic               w_skid_load;
  logic               w_skid_clear;
  logic               w_skid_valid;
  logic [INSTR_W-1:0] w_skid_data;
  logic [ADDR_W-1:0]  w_skid_pc;
  logic [INSTR_W-1:0] w_slot_data;
  logic [ADDR_W-1:0]  w_slot_pc;

  logic               r_if_valid;
  logic [INSTR_W-1:0] r_if_instr;
  logic [ADDR_W-1:0]  r_if_pc;
  logic [ADDR_W-1:0]  r_if_pc_next;

  assign w_pc_inc = r_pc + ADDR_W'(PC_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Redirect outranks stall and any response; a grant or response that
  // coincides with it decides whether a drain is still owed.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_load       = 1'b0;
    w_from_skid  = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    if (redirect) begin
      w_pc_nxt     = redirect_pc;
      w_skid_clear = 1'b1;
      case (r_state)
        REQ:         w_state_nxt = imem_gnt ? DRAIN : REQ;
        WAIT, DRAIN: w_state_nxt = imem_rvalid ? REQ : DRAIN;
        default:     w_state_nxt = REQ;
      endcase
    end else begin
      case (r_state)
        IDLE: w_state_nxt = REQ;
        REQ:  if (imem_gnt) w_state_nxt = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (stall) begin
              w_skid_load = 1'b1;
              w_state_nxt = HOLD;
            end else begin
              w_load      = 1'b1;
              w_pc_nxt    = w_pc_inc;
              w_state_nxt = REQ;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            w_load       = 1'b1;
            w_from_skid  = 1'b1;
            w_skid_clear = 1'b1;
            w_pc_nxt     = w_pc_inc;
            w_state_nxt  = REQ;
          end
        end
        DRAIN:   if (imem_rvalid) w_state_nxt = REQ;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  fetch_skid_reg #(.ADDR_W(ADDR_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (imem_rdata),
    .i_pc    (r_pc),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_pc    (w_skid_pc)
  );

  assign w_slot_data = w_from_skid ? w_skid_data : imem_rdata;
  assign w_slot_pc   = w_from_skid ? w_skid_pc   : r_pc;

  // Without a stall the slot is consumed every cycle, so if_valid is a
  // one-cycle pulse per instruction unless decode holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid   <= 1'b0;
      r_if_instr   <= '0;
      r_if_pc      <= '0;
      r_if_pc_next <= '0;
    end else if (redirect) begin
      r_if_valid <= 1'b0;
    end else if (!stall) begin
      r_if_valid <= w_load;
      if (w_load) begin
        r_if_instr   <= w_slot_data;
        r_if_pc      <= w_slot_pc;
        r_if_pc_next <= w_slot_pc + ADDR_W'(PC_STEP);
      end
    end
  end

  assign imem_req   = (r_state == REQ);
  assign imem_addr  = r_pc;
  assign if_valid   = r_if_valid;
  assign if_instr   = r_if_instr;
  assign if_pc      = r_if_pc;
  assign if_pc_next = r_if_pc_next;
  assign if_op      = r_if_instr[OP_HI:OP_LO];
  assign if_funct   = r_if_instr[FUNCT_HI:FUNCT_LO];
  assign if_rd      = r_if_instr[RD_HI:RD_LO];
  assign dbg_state  = r_state;

`ifndef SYNTHESIS
  a_rsp_while_idle_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (r_state == IDLE || r_state == REQ)));
  a_gnt_outside_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_gnt && r_state != REQ));
  a_hold_has_skid: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_state == HOLD && !w_skid_valid));
`endif

endmodule

// File: tb/tb_fetch_unit_pipe.sv
// Bench for fetch_unit_pipe: directed scenarios followed by random stall,
// redirect and memory latency, checked against a program-order PC model.
module tb_fetch_unit_pipe;
  import cpu_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stall = 1'b0;
  logic         redirect = 1'b0;
  logic [31:0]  redirect_pc = '0;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt = 1'b0;
  logic         imem_rvalid = 1'b0;
  logic [31:0]  imem_rdata = '0;
  logic         if_valid;
  logic [31:0]  if_instr;
  logic [31:0]  if_pc;
  logic [31:0]  if_pc_next;
  logic [1:0]   if_op;
  logic [3:0]   if_funct;
  logic [3:0]   if_rd;
  fetch_state_t dbg_state;

  fetch_unit_pipe #(.ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_next(if_pc_next), .if_op(if_op), .if_funct(if_funct),
    .if_rd(if_rd), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] exp_pc = 32'h0;
  int          consumed = 0;
  int          gap = 0;
  int          max_gap = 0;
  bit          pend_v = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          lat_mode = 0;
  bit          gnt_always = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hE000_0001;
    if (a == 32'h4) return 32'h0400_1002;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory side: at most one outstanding request, response after a latency.
  task automatic sample();
    @(negedge clk);
    cyc++;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    if (pend_v) begin
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata = mem_word(pend_addr);
        pend_v = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (imem_req && !pend_v && !imem_rvalid && (gnt_always || $urandom_range(0, 3) != 0)) begin
      imem_gnt = 1'b1;
      pend_v = 1'b1;
      pend_addr = imem_addr;
      pend_cnt = (lat_mode < 0) ? int'($urandom_range(0, 2)) : lat_mode;
    end
  endtask

  // Decode side: a live slot with no stall is consumed and must be the next
  // instruction in program order; a redirect restarts program order.
  task automatic drive(input logic s, input logic r, input logic [31:0] rpc);
    logic [31:0] w;
    if (if_valid && !s) begin
      w = mem_word(exp_pc);
      chk("if_pc", if_pc, exp_pc);
      chk("if_instr", if_instr, w);
      chk("if_pc_next", if_pc_next, exp_pc + 32'd4);
      chk("if_op", 32'(if_op), 32'(w[27:26]));
      chk("if_funct", 32'(if_funct), 32'(w[25:22]));
      chk("if_rd", 32'(if_rd), 32'(w[15:12]));
      exp_pc = exp_pc + 32'd4;
      consumed++;
      gap = 0;
    end else begin
      gap++;
    end
    if (gap > max_gap) max_gap = gap;
    if (r) exp_pc = rpc;
    stall = s;
    redirect = r;
    redirect_pc = rpc;
  endtask

  task automatic seek_state(input fetch_state_t st, input bit need_rvalid, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      sample();
      if (dbg_state == st && (!need_rvalid || imem_rvalid)) begin
        found = 1'b1;
        break;
      end
      drive(1'b0, 1'b0, 32'h0);
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    logic [31:0] s_pc, s_instr;
    logic s_valid;
    logic s, r;
    logic [31:0] rpc;

    repeat (2) @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_pc_next", if_pc_next, 32'h0);
    rst_n = 1'b1;
    cyc = 0;

    // Zero-wait memory: first instruction three cycles after release.
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (if_valid) begin found = 1'b1; break; end
      drive(1'b0, 1'b0, 32'h0);
    end
    chk("first_valid_cycle", 32'(cyc), 32'd3);
    chk("first_pc", if_pc, 32'h0);
    chk("first_pc_next", if_pc_next, 32'h4);
    chk("first_op", 32'(if_op), 32'd0);
    drive(1'b0, 1'b0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (if_valid) begin found = 1'b1; break; end
      drive(1'b0, 1'b0, 32'h0);
    end
    chk("second_found", 32'(found), 32'd1);
    chk("second_pc", if_pc, 32'h4);
    chk("second_op", 32'(if_op), 32'd1);
    chk("second_funct", 32'(if_funct), 32'd0);
    chk("second_rd", 32'(if_rd), 32'd1);
    drive(1'b0, 1'b0, 32'h0);

    // Stall for three cycles while a response arrives.
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (if_valid && imem_req) begin found = 1'b1; break; end
      drive(1'b0, 1'b0, 32'h0);
    end
    chk("stall_setup", 32'(found), 32'd1);
    s_valid = if_valid; s_pc = if_pc; s_instr = if_instr;
    drive(1'b1, 1'b0, 32'h0);
    for (int j = 0; j < 3; j++) begin
      sample();
      chk("stall_frozen_valid", 32'(if_valid), 32'(s_valid));
      chk("stall_frozen_pc", if_pc, s_pc);
      chk("stall_frozen_instr", if_instr, s_instr);
      if (j > 0) chk("stall_hold_state", 32'(dbg_state), 32'(HOLD));
      drive(j < 2, 1'b0, 32'h0);
    end
    for (int i = 0; i < 8; i++) begin sample(); drive(1'b0, 1'b0, 32'h0); end

    // Redirect in WAIT with the response two cycles later.
    lat_mode = 2;
    seek_state(WAIT, 1'b0, "wait_found");
    drive(1'b0, 1'b1, 32'h40);
    sample();
    chk("flush_valid", 32'(if_valid), 32'd0);
    chk("drain_state", 32'(dbg_state), 32'(DRAIN));
    drive(1'b0, 1'b0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (imem_req) begin found = 1'b1; break; end
      drive(1'b0, 1'b0, 32'h0);
    end
    chk("redir_req_found", 32'(found), 32'd1);
    chk("redir_addr", imem_addr, 32'h40);
    drive(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin sample(); drive(1'b0, 1'b0, 32'h0); end

    // Redirect in the same cycle as a response under stall.
    lat_mode = 0;
    seek_state(WAIT, 1'b1, "wait_rvalid_found");
    drive(1'b1, 1'b1, 32'h80);
    sample();
    chk("same_cyc_state", 32'(dbg_state), 32'(REQ));
    chk("same_cyc_addr", imem_addr, 32'h80);
    chk("same_cyc_valid", 32'(if_valid), 32'd0);
    drive(1'b1, 1'b0, 32'h0);
    sample(); drive(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin sample(); drive(1'b0, 1'b0, 32'h0); end

    // PC wrap at the top of the address space.
    sample();
    drive(1'b0, 1'b1, 32'hFFFF_FFFC);
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      sample();
      if (imem_gnt) begin
        n++;
        if (n == 1) chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        else chk("wrap_addr_zero", imem_addr, 32'h0);
      end
      drive(1'b0, 1'b0, 32'h0);
    end
    chk("wrap_grants", 32'(n), 32'd2);
    for (int i = 0; i < 6; i++) begin sample(); drive(1'b0, 1'b0, 32'h0); end

    // Asynchronous reset while a request is outstanding.
    lat_mode = 2;
    seek_state(WAIT, 1'b0, "rst_wait_found");
    drive(1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_if_valid", 32'(if_valid), 32'd0);
    chk("arst_if_instr", if_instr, 32'h0);
    chk("arst_if_pc", if_pc, 32'h0);
    chk("arst_if_pc_next", if_pc_next, 32'h0);
    chk("arst_imem_req", 32'(imem_req), 32'd0);
    chk("arst_imem_addr", imem_addr, 32'h0);
    chk("arst_state", 32'(dbg_state), 32'(IDLE));
    pend_v = 1'b0;
    exp_pc = 32'h0;
    @(negedge clk);
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    stall = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    rst_n = 1'b1;
    cyc = 0;
    lat_mode = 0;
    n = consumed;
    for (int i = 0; i < 8; i++) begin sample(); drive(1'b0, 1'b0, 32'h0); end
    chk("arst_restart", 32'(consumed - n > 0), 32'd1);

    // Random traffic.
    lat_mode = -1;
    gnt_always = 1'b0;
    consumed = 0;
    max_gap = 0;
    gap = 0;
    for (int i = 0; i < 3000; i++) begin
      sample();
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 255)) << 2);
      drive(s, r, rpc);
    end
    chk("progress", 32'((max_gap < 100) && (consumed > 150)), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
